fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_if.sv | 44 ++++
 rtl/fetch_buffer.sv | 55 +++++
 rtl/fetch_unit.sv | 92 +++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/fetch_if.sv
// ROM, redirect and decode-side signals of the fetch unit.
interface fetch_if #(
    parameter int unsigned ADDRESS_WIDTH = 20
);
    logic [ADDRESS_WIDTH-1:0] rom_addr;
    logic [31:0]              rom_rdata;
    logic                     redirect;
    logic [31:0]              redirect_pc;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_instr;
    logic [31:0]              out_pc;
    logic [31:0]              out_pc_plus4;
    logic                     halted;

    // Fetch unit side.
    modport master (
        output rom_addr,
        input  rom_rdata,
        input  redirect,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4,
        output halted
    );

    // ROM / pipeline-control / decode side.
    modport slave (
        input  rom_addr,
        output rom_rdata,
        output redirect,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4,
        input  halted
    );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr}; push when full and pop when empty are ignored.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  fetch_entry_t i_entry,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count,
    output logic         o_full,
    output logic         o_empty
);

    fetch_entry_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    // Guard the raw requests against overflow and underflow.
    always_comb begin
        o_full  = (r_count == 2'd2);
        o_empty = (r_count == 2'd0);
        w_push  = i_push && !o_full;
        w_pop   = i_pop && !o_empty;
        o_count = r_count;
        o_head  = r_mem[r_rd_ptr];
    end

    // Storage, pointers and occupancy; flush clears contents as well as count.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, RUN/HALT control and a 2-deep decode buffer.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 20,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
    input  logic   clk,
    input  logic   rst,
    fetch_if.master io_bus
);

    logic [31:0]  r_pc;
    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic         w_fetch;
    logic         w_is_ebreak;
    logic         w_pop;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;
    logic [1:0]   w_count;
    logic         w_full;
    logic         w_empty;
    logic [1:0]   w_unused_pc_lsb;

    // Fetch/pop decisions; redirect suppresses both.
    always_comb begin
        w_is_ebreak     = (io_bus.rom_rdata == INSTR_EBREAK);
        w_fetch         = (r_state == RUN) && !io_bus.redirect && (w_count < 2'd2);
        w_pop           = io_bus.out_ready && !io_bus.redirect;
        w_push_entry    = '{pc: r_pc, instr: io_bus.rom_rdata};
        w_unused_pc_lsb = io_bus.redirect_pc[1:0];
    end

    // FSM next state: EBREAK fetch halts, any redirect resumes.
    always_comb begin
        w_state_next = r_state;
        if (io_bus.redirect) begin
            w_state_next = RUN;
        end else if (w_fetch && w_is_ebreak) begin
            w_state_next = HALT;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC: redirect target, else step past each non-EBREAK fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (io_bus.redirect) begin
            r_pc <= {io_bus.redirect_pc[31:2], 2'b00};
        end else if (w_fetch && !w_is_ebreak) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    fetch_buffer u_buffer (
        .clk     (clk),
        .rst     (rst),
        .i_flush (io_bus.redirect),
        .i_push  (w_fetch),
        .i_pop   (w_pop),
        .i_entry (w_push_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Output drive from the PC and the buffer head.
    always_comb begin
        io_bus.rom_addr     = r_pc[ADDRESS_WIDTH-1:0];
        io_bus.out_valid    = !w_empty;
        io_bus.out_instr    = w_head.instr;
        io_bus.out_pc       = w_head.pc;
        io_bus.out_pc_plus4 = w_head.pc + PC_STEP;
        io_bus.halted       = (r_state == HALT);
    end

    // Fullness is already folded into w_count; keep the flag for waveform debug.
    logic w_unused_full;
    assign w_unused_full = w_full;

endmodule
